pc_trace_monitor: RTL and testbench

Synthesizable run controller and execution trace buffer for the DataPath. Each cycle it samples the fetch-side signals (pcQ, pcD, instruction, regWriteEnable), stamps them with a cycle count and stores them in a parametrised circular buffer. A valid/ready port drains the buffer. It asserts halt after a programmable cycle limit, so the per-cycle display and fixed-count stop no longer live in testbench-only code.

---
 rtl/pc_trace_monitor.sv | 139 +++++++++++++
 tb/tb_pc_trace_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_trace_monitor.sv
// Run controller and circular execution-trace buffer for the DataPath.
// Captures fetch-side state each enabled cycle; halts after a cycle limit.
module pc_trace_monitor #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int CYCLE_LIMIT = 20
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   enable,
  input  logic                   restart,
  input  logic                   wrapMode,
  input  logic [ADDR_WIDTH-1:0]  pcQ,
  input  logic [ADDR_WIDTH-1:0]  pcD,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   regWriteEnable,
  output logic                   halt,
  output logic [CNT_WIDTH-1:0]   cycleCount,
  output logic [$clog2(DEPTH):0] entryCount,
  output logic                   overflow,
  output logic                   readValid,
  input  logic                   readReady,
  output logic [CNT_WIDTH-1:0]   readCycle,
  output logic [ADDR_WIDTH-1:0]  readPc,
  output logic [ADDR_WIDTH-1:0]  readPcNext,
  output logic [INSTR_WIDTH-1:0] readInstr,
  output logic                   readRegWrite
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = PW + 1;

  typedef struct packed {
    logic [CNT_WIDTH-1:0]   cyc;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pcNext;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   regWrite;
  } entry_t;

  typedef enum logic {RUN, HALTED} state_t;

  state_t         state;
  state_t         stateNext;
  entry_t         mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [EW-1:0]  count;
  logic [EW-1:0]  countNext;
  logic [CNT_WIDTH-1:0] cycCnt;
  logic           ovf;
  logic           full;
  logic           push;
  logic           pop;
  logic           atLimit;
  logic           write;
  logic           advHead;
  logic           lost;

  assign full    = (count == EW'(DEPTH));
  assign push    = (state == RUN) && enable;
  assign pop     = (count != '0) && readReady;
  assign atLimit = (CYCLE_LIMIT != 0) &&
                   (cycCnt == CNT_WIDTH'(CYCLE_LIMIT - 1));
  assign write   = push && (!full || pop || wrapMode);
  assign advHead = pop || (push && full && wrapMode);
  assign lost    = push && full && !pop;

  // A full buffer keeps its size on a push unless only a pop happens.
  assign countNext = count
                   + EW'(push && !full)
                   - EW'(pop && !(push && full));

  always_comb begin
    stateNext = state;
    if (restart) begin
      stateNext = RUN;
    end else if (push && atLimit) begin
      stateNext = HALTED;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      cycCnt <= '0;
      ovf    <= 1'b0;
    end else if (restart) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      cycCnt <= '0;
      ovf    <= 1'b0;
    end else begin
      if (write) begin
        mem[tail] <= '{cycCnt, pcQ, pcD,
                       instruction, regWriteEnable};
        tail      <= tail + PW'(1);
      end
      if (advHead) begin
        head <= head + PW'(1);
      end
      if (push) begin
        cycCnt <= cycCnt + CNT_WIDTH'(1);
      end
      if (lost) begin
        ovf <= 1'b1;
      end
      count <= countNext;
    end
  end

  assign halt         = (state == HALTED);
  assign cycleCount   = cycCnt;
  assign entryCount   = count;
  assign overflow     = ovf;
  assign readValid    = (count != '0);
  assign readCycle    = mem[head].cyc;
  assign readPc       = mem[head].pc;
  assign readPcNext   = mem[head].pcNext;
  assign readInstr    = mem[head].instr;
  assign readRegWrite = mem[head].regWrite;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Bench for pc_trace_monitor: queue-based trace model plus
// directed scenarios with literal expectations.
module tb_pc_trace_monitor;

  logic        clock = 1'b0;
  logic        resetN;
  logic        enable;
  logic        restart;
  logic        wrapMode;
  logic [31:0] pcQ;
  logic [31:0] pcD;
  logic [31:0] instruction;
  logic        regWriteEnable;
  logic        halt;
  logic [15:0] cycleCount;
  logic [4:0]  entryCount;
  logic        overflow;
  logic        readValid;
  logic        readReady;
  logic [15:0] readCycle;
  logic [31:0] readPc;
  logic [31:0] readPcNext;
  logic [31:0] readInstr;
  logic        readRegWrite;

  pc_trace_monitor dut (
    .clock(clock),
    .resetN(resetN),
    .enable(enable),
    .restart(restart),
    .wrapMode(wrapMode),
    .pcQ(pcQ),
    .pcD(pcD),
    .instruction(instruction),
    .regWriteEnable(regWriteEnable),
    .halt(halt),
    .cycleCount(cycleCount),
    .entryCount(entryCount),
    .overflow(overflow),
    .readValid(readValid),
    .readReady(readReady),
    .readCycle(readCycle),
    .readPc(readPc),
    .readPcNext(readPcNext),
    .readInstr(readInstr),
    .readRegWrite(readRegWrite)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    logic [31:0] pc;
    logic [31:0] pcn;
    logic [31:0] ins;
    logic        rw;
  } rec_t;

  localparam int DEPTH = 16;
  localparam int LIMIT = 20;

  rec_t        mq[$];
  int unsigned mCnt;
  bit          mHalt;
  bit          mOvf;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  function automatic void modelClear();
    mq.delete();
    mCnt  = 0;
    mHalt = 0;
    mOvf  = 0;
  endfunction

  // Trace semantics: pop sees the pre-edge head, push then appends.
  function automatic void modelEdge();
    rec_t r;
    if (restart) begin
      modelClear();
      return;
    end
    if (mq.size() != 0 && readReady) void'(mq.pop_front());
    if (!mHalt && enable) begin
      r.cyc = mCnt;
      r.pc  = pcQ;
      r.pcn = pcD;
      r.ins = instruction;
      r.rw  = regWriteEnable;
      if (mq.size() < DEPTH) begin
        mq.push_back(r);
      end else begin
        mOvf = 1;
        if (wrapMode) begin
          void'(mq.pop_front());
          mq.push_back(r);
        end
      end
      if (mCnt == LIMIT - 1) mHalt = 1;
      mCnt = (mCnt + 1) % 65536;
    end
  endfunction

  task automatic compareAll();
    chk("halt", halt, mHalt);
    chk("cycleCount", cycleCount, mCnt);
    chk("entryCount", entryCount, mq.size());
    chk("overflow", overflow, mOvf);
    chk("readValid", readValid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("readCycle", readCycle, mq[0].cyc);
      chk("readPc", readPc, mq[0].pc);
      chk("readPcNext", readPcNext, mq[0].pcn);
      chk("readInstr", readInstr, mq[0].ins);
      chk("readRegWrite", readRegWrite, mq[0].rw);
    end
  endtask

  task automatic step(bit en, bit rs, bit wr, bit rdy,
                      logic [31:0] pq, logic [31:0] pd);
    enable         = en;
    restart        = rs;
    wrapMode       = wr;
    readReady      = rdy;
    pcQ            = pq;
    pcD            = pd;
    instruction    = $urandom;
    regWriteEnable = 1'($urandom_range(1));
    @(posedge clock);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic capture(int n, bit wr, bit rdy);
    for (int i = 0; i < n; i++) begin
      step(1, 0, wr, rdy, 32'(4 * i), 32'(4 * i + 4));
    end
  endtask

  task automatic zeroChecks(string tag);
    chk({tag, "Halt"}, halt, 0);
    chk({tag, "Cycle"}, cycleCount, 0);
    chk({tag, "Entries"}, entryCount, 0);
    chk({tag, "Ovf"}, overflow, 0);
    chk({tag, "Valid"}, readValid, 0);
    chk({tag, "RdCycle"}, readCycle, 0);
    chk({tag, "RdPc"}, readPc, 0);
    chk({tag, "RdInstr"}, readInstr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    resetN = 0;
    enable = 0;
    restart = 0;
    wrapMode = 0;
    readReady = 0;
    pcQ = 0;
    pcD = 0;
    instruction = 0;
    regWriteEnable = 0;
    modelClear();
    #12;
    zeroChecks("reset");
    @(negedge clock);
    resetN = 1;

    // Discard-when-full run to the limit, then drain.
    capture(LIMIT, 0, 0);
    chk("t1Halt", halt, 1);
    chk("t1Cycle", cycleCount, 20);
    chk("t1Entries", entryCount, 16);
    chk("t1Ovf", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      chk("t1Stamp", readCycle, i);
      chk("t1Pc", readPc, 4 * i);
      step(1, 0, 0, 1, 0, 0);
    end
    chk("t1Empty", readValid, 0);
    chk("t1Frozen", cycleCount, 20);

    // Overwrite-oldest run.
    step(0, 1, 1, 0, 0, 0);
    capture(LIMIT, 1, 0);
    chk("t2Ovf", overflow, 1);
    chk("t2Entries", entryCount, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t2Stamp", readCycle, 4 + i);
      chk("t2Pc", readPc, 32'h10 + 4 * i);
      step(0, 0, 1, 1, 0, 0);
    end

    // Continuous drain while capturing.
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 4);
    chk("t3Valid", readValid, 1);
    chk("t3Stamp0", readCycle, 0);
    for (int i = 1; i < 10; i++) begin
      step(1, 0, 0, 1, 32'(4 * i), 32'(4 * i + 4));
      chk("t3Le1", entryCount <= 1, 1);
      chk("t3Stamp", readCycle, i);
    end
    chk("t3Ovf", overflow, 0);

    // Full buffer with simultaneous push and pop.
    step(0, 1, 0, 0, 0, 0);
    capture(16, 0, 0);
    chk("t4Full", entryCount, 16);
    chk("t4Head0", readCycle, 0);
    step(1, 0, 0, 1, 32'h40, 32'h44);
    chk("t4Entries", entryCount, 16);
    chk("t4Ovf", overflow, 0);
    chk("t4Head1", readCycle, 1);

    // Enable gaps.
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 4);
    step(0, 0, 0, 0, 4, 8);
    step(1, 0, 0, 0, 8, 12);
    step(1, 0, 0, 0, 12, 16);
    chk("t5Entries", entryCount, 3);
    chk("t5Cycle", cycleCount, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t5Stamp", readCycle, i);
      step(0, 0, 0, 1, 0, 0);
    end

    // Restart while halted with data pending.
    step(0, 1, 0, 0, 0, 0);
    capture(LIMIT, 0, 0);
    chk("t6Halted", halt, 1);
    chk("t6Pending", readValid, 1);
    step(1, 1, 0, 1, 0, 0);
    chk("t6Halt", halt, 0);
    chk("t6Entries", entryCount, 0);
    chk("t6Ovf", overflow, 0);
    chk("t6Cycle", cycleCount, 0);

    // Asynchronous reset mid-capture.
    capture(5, 0, 0);
    #2;
    resetN = 0;
    #1;
    zeroChecks("async");
    modelClear();
    @(negedge clock);
    resetN = 1;

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(99) < 70),
           1'($urandom_range(99) < 3),
           1'($urandom_range(1)),
           1'($urandom_range(99) < 35),
           $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
